// File: rtl/bus_test_driver_if.sv
// bus_test_driver_if: shared datapath bus connection between the pattern driver and the
// top-level tri-state/bus resolution logic.
interface bus_test_driver_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_in;

    modport master (output bus_out, output bus_oe, input bus_in);
    modport slave  (input bus_out, input bus_oe, output bus_in);
endinterface

// File: rtl/bus_test_driver.sv
// bus_test_driver: single-step pattern generator and bus capture FIFO for LED readout.
// Optional loopback checker enabled by defining BUS_TEST_LOOPBACK_CHECK_EN.
module bus_test_driver #(
    parameter int                DATA_W = 16,
    parameter int                DEPTH  = 8,
    parameter logic [DATA_W-1:0] SEED   = 16'h5500,
    parameter logic [DATA_W-1:0] TAPS   = 16'hB400
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step,
    input  logic                       drive_en,
    input  logic [1:0]                 mode,
    input  logic                       load,
    input  logic [DATA_W-1:0]          load_val,
    bus_test_driver_if.master          bus,
    input  logic                       cap_en,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic [7:0]                 err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] pat, adv, pat_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push_req, push, pop, drop;

    assign bus.bus_out = pat;
    assign bus.bus_oe  = drive_en & reset;
    assign empty       = count == '0;
    assign full        = count == CW'(DEPTH);
    assign rd_data     = empty ? '0 : mem[rd_ptr];
    assign pop         = rd_en & ~empty;
    assign push_req    = step & cap_en & ~drive_en;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign push        = push_req & (~full | pop);
    assign drop        = push_req & full & ~pop;

    always_comb begin
        adv     = mode == 2'b00 ? pat :
                  mode == 2'b01 ? pat + 1'b1 :
                  mode == 2'b10 ? {pat[DATA_W-2:0], pat[DATA_W-1]} :
                  pat == '0     ? SEED : (pat >> 1) ^ (pat[0] ? TAPS : '0);
        pat_nxt = load ? load_val : drive_en ? adv : pat;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pat      <= SEED;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (step) pat <= pat_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(push) - CW'(pop);
            overflow <= drop | (overflow & ~clr_ovf);
        end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.bus_in;

`ifdef BUS_TEST_LOOPBACK_CHECK_EN
    // Compares against the pattern currently on the bus, before this step's update.
    always_ff @(posedge clk or negedge reset)
        if (!reset) err_count <= 8'h00;
        else if (step && drive_en && cap_en && bus.bus_in != pat && err_count != 8'hFF)
            err_count <= err_count + 8'h01;
`else
    assign err_count = 8'h00;
`endif
endmodule
